// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle RV32I fetch/control sequencer with handshaked memories.
// Define PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module mc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            br_taken,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    output logic            rf_we,
    output logic            wb_link,
    output logic [2:0]      state,
    output logic            halted
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [6:0]      w_op;
    logic            w_load, w_store, w_branch, w_jal, w_jalr, w_valid;
    logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_j, w_pc4, w_pc_br, w_pc_jalr;

    assign w_op     = r_ir[6:0];
    assign w_load   = w_op == 7'b0000011;
    assign w_store  = w_op == 7'b0100011;
    assign w_branch = w_op == 7'b1100011;
    assign w_jal    = w_op == 7'b1101111;
    assign w_jalr   = w_op == 7'b1100111;
    assign w_valid  = w_load | w_store | w_branch | w_jal | w_jalr | w_op == 7'b0110011 |
                      w_op == 7'b0010011 | w_op == 7'b0110111 | w_op == 7'b0010111;

    assign w_imm_i   = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b   = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j   = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_pc4     = r_pc + XLEN'(4);
    assign w_pc_br   = r_pc + (br_taken ? w_imm_b : XLEN'(4));
    assign w_pc_jalr = (rs1_data + w_imm_i) & ~XLEN'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= NOP;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ready) begin
                    r_ir    <= imem_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: r_state <= w_valid ? S_EXEC : S_HALT;
                S_EXEC: begin
                    r_state <= w_branch ? S_FETCH : (w_load | w_store) ? S_MEM : S_WB;
                    if (w_branch) r_pc <= w_pc_br;
                end
                S_MEM: if (dmem_ready) begin
                    r_state <= w_store ? S_FETCH : S_WB;
                    if (w_store) r_pc <= w_pc4;
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_jal ? r_pc + w_imm_j : w_jalr ? w_pc_jalr : w_pc4;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Strobes are gated by rst so they read low while reset is held.
    assign imem_req = ~rst & (r_state == S_FETCH);
    assign dmem_req = ~rst & (r_state == S_MEM);
    assign dmem_we  = dmem_req & w_store;
    assign rf_we    = ~rst & (r_state == S_WB);
    assign wb_link  = rf_we & (w_jal | w_jalr);
    assign halted   = r_state == S_HALT;
    assign state    = r_state;
    assign pc       = r_pc;
    assign ir       = r_ir;

`ifdef PERF_CNT_EN
    logic [63:0] r_cycle, r_instret;
    logic        w_retire;

    assign w_retire = (r_state == S_EXEC & w_branch) | (dmem_req & dmem_ready & w_store) | (r_state == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (!halted) r_cycle <= r_cycle + 64'd1;
            if (w_retire) r_instret <= r_instret + 64'd1;
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scoreboard bench; stimulus queues per-cycle expectations, a monitor pops and checks them.
module tb_mc_sequencer;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] JAL  = 32'h00C0_006F;
    localparam logic [31:0] BEQ  = 32'h0000_0463;
    localparam logic [31:0] JALR = 32'h00C0_8067;
    localparam logic [31:0] LW   = 32'h0000_2083;
    localparam logic [31:0] SW   = 32'h0010_2023;
    localparam logic [31:0] OPR  = 32'h0000_0033;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        ireq, dreq, dwe, rfwe, link, hlt, perf;
        logic [63:0] cyc, inst;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        imem_req, imem_ready = 0, dmem_req, dmem_we, dmem_ready = 0, br_taken = 0;
    logic [31:0] imem_rdata = 0, rs1_data = 0, pc, ir;
    logic        rf_we, wb_link, halted;
    logic [2:0]  state;
    logic [63:0] cycle_cnt, instret_cnt;
    logic        g_perf = 0;
    logic [63:0] g_cyc = 0, g_inst = 0;
    int          n_chk = 0, n_fail = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    mc_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rs1_data(rs1_data), .br_taken(br_taken),
        .pc(pc), .ir(ir), .rf_we(rf_we), .wb_link(wb_link), .state(state), .halted(halted)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

`ifndef PERF_CNT_EN
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
        end
    endfunction

    task automatic step(input logic i_rdy, input logic [31:0] rdata, input logic d_rdy,
                        input logic [31:0] rs1, input logic br, input logic [2:0] st,
                        input logic [31:0] epc, input logic [31:0] eir, input logic link, input logic dwe);
        exp_t e;
        imem_ready = i_rdy;
        imem_rdata = rdata;
        dmem_ready = d_rdy;
        rs1_data   = rs1;
        br_taken   = br;
        e.st   = st;
        e.pc   = epc;
        e.ir   = eir;
        e.ireq = !rst && st == 3'd0;
        e.dreq = !rst && st == 3'd3;
        e.dwe  = dwe;
        e.rfwe = !rst && st == 3'd4;
        e.link = link;
        e.hlt  = st == 3'd5;
        e.perf = g_perf;
        e.cyc  = g_cyc;
        e.inst = g_inst;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("state", 64'(state), 64'(e.st));
            chk("pc", 64'(pc), 64'(e.pc));
            chk("ir", 64'(ir), 64'(e.ir));
            chk("imem_req", 64'(imem_req), 64'(e.ireq));
            chk("dmem_req", 64'(dmem_req), 64'(e.dreq));
            chk("dmem_we", 64'(dmem_we), 64'(e.dwe));
            chk("rf_we", 64'(rf_we), 64'(e.rfwe));
            chk("wb_link", 64'(wb_link), 64'(e.link));
            chk("halted", 64'(halted), 64'(e.hlt));
`ifdef PERF_CNT_EN
            if (e.perf) begin
                chk("cycle_cnt", cycle_cnt, e.cyc);
                chk("instret_cnt", instret_cnt, e.inst);
            end
`endif
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 3'd0, 32'h0, NOP, 0, 0);
        rst = 0;
        // addi: FETCH, DECODE, EXEC, WB; stray dmem_ready/br_taken ignored
        step(1, ADDI, 0, 0, 0, 3'd0, 32'h0, NOP, 0, 0);
        step(1, ADDI, 1, 0, 1, 3'd1, 32'h0, ADDI, 0, 0);
        step(1, ADDI, 1, 0, 1, 3'd2, 32'h0, ADDI, 0, 0);
        step(1, JAL, 0, 0, 0, 3'd4, 32'h0, ADDI, 0, 0);
        // jal +12 from 0x4
        step(1, JAL, 0, 0, 0, 3'd0, 32'h4, ADDI, 0, 0);
        step(0, 0, 0, 0, 0, 3'd1, 32'h4, JAL, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'h4, JAL, 0, 0);
        step(0, 0, 0, 0, 0, 3'd4, 32'h4, JAL, 1, 0);
        // beq +8 taken at 0x10, then not taken at 0x18
        step(1, BEQ, 0, 0, 0, 3'd0, 32'h10, JAL, 0, 0);
        step(0, 0, 0, 0, 1, 3'd1, 32'h10, BEQ, 0, 0);
        step(0, 0, 0, 0, 1, 3'd2, 32'h10, BEQ, 0, 0);
        step(1, BEQ, 0, 0, 1, 3'd0, 32'h18, BEQ, 0, 0);
        step(0, 0, 0, 0, 1, 3'd1, 32'h18, BEQ, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'h18, BEQ, 0, 0);
        // one fetch wait, then jalr x0,12(x1) with rs1=0x101
        step(0, JALR, 0, 0, 0, 3'd0, 32'h1C, BEQ, 0, 0);
        step(1, JALR, 0, 0, 0, 3'd0, 32'h1C, BEQ, 0, 0);
        step(0, 0, 0, 0, 0, 3'd1, 32'h1C, JALR, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'h1C, JALR, 0, 0);
        step(0, 0, 0, 32'h101, 0, 3'd4, 32'h1C, JALR, 1, 0);
        // load with three data wait cycles
        step(1, LW, 0, 0, 0, 3'd0, 32'h10C, JALR, 0, 0);
        step(0, 0, 1, 0, 0, 3'd1, 32'h10C, LW, 0, 0);
        step(0, 0, 1, 0, 0, 3'd2, 32'h10C, LW, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 3'd3, 32'h10C, LW, 0, 0);
        step(0, 0, 1, 0, 0, 3'd3, 32'h10C, LW, 0, 0);
        step(0, 0, 0, 0, 0, 3'd4, 32'h10C, LW, 0, 0);
        // store, zero wait
        step(1, SW, 0, 0, 0, 3'd0, 32'h110, LW, 0, 0);
        step(0, 0, 0, 0, 0, 3'd1, 32'h110, SW, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'h110, SW, 0, 0);
        step(0, 0, 1, 0, 0, 3'd3, 32'h110, SW, 0, 1);
        // jalr to 0xFFFFFFFC, then addi wraps pc to 0
        step(1, JALR, 0, 0, 0, 3'd0, 32'h114, SW, 0, 0);
        step(0, 0, 0, 0, 0, 3'd1, 32'h114, JALR, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'h114, JALR, 0, 0);
        step(0, 0, 0, 32'hFFFF_FFF0, 0, 3'd4, 32'h114, JALR, 1, 0);
        step(1, ADDI, 0, 0, 0, 3'd0, 32'hFFFF_FFFC, JALR, 0, 0);
        step(0, 0, 0, 0, 0, 3'd1, 32'hFFFF_FFFC, ADDI, 0, 0);
        step(0, 0, 0, 0, 0, 3'd2, 32'hFFFF_FFFC, ADDI, 0, 0);
        step(0, 0, 0, 0, 0, 3'd4, 32'hFFFF_FFFC, ADDI, 0, 0);
        // illegal opcode halts; HALT absorbs until reset
        step(1, HLT, 0, 0, 0, 3'd0, 32'h0, ADDI, 0, 0);
        step(1, HLT, 1, 0, 1, 3'd1, 32'h0, HLT, 0, 0);
        for (int i = 0; i < 3; i++) step(1, ADDI, 1, 0, 1, 3'd5, 32'h0, HLT, 0, 0);
        rst = 1;
        step(0, 0, 0, 0, 0, 3'd0, 32'h0, NOP, 0, 0);
        rst = 0;
        step(0, 0, 0, 0, 0, 3'd0, 32'h0, NOP, 0, 0);
`ifdef PERF_CNT_EN
        rst = 1;
        g_perf = 1;
        step(0, 0, 0, 0, 0, 3'd0, 32'h0, NOP, 0, 0);
        rst = 0;
        g_perf = 0;
        for (int k = 0; k < 3; k++) begin
            step(1, OPR, 0, 0, 0, 3'd0, 32'(4 * k), (k == 0) ? NOP : OPR, 0, 0);
            step(0, 0, 0, 0, 0, 3'd1, 32'(4 * k), OPR, 0, 0);
            step(0, 0, 0, 0, 0, 3'd2, 32'(4 * k), OPR, 0, 0);
            step(0, 0, 0, 0, 0, 3'd4, 32'(4 * k), OPR, 0, 0);
        end
        g_perf = 1;
        g_cyc  = 64'd12;
        g_inst = 64'd3;
        step(0, 0, 0, 0, 0, 3'd0, 32'hC, OPR, 0, 0);
`endif
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
